// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one fetch at a time, buffers the returned
// instruction for decode, and handles redirects that race with in-flight responses.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] io_pc,
  output logic        io_pc_valid,
  input  logic [31:0] io_inst,
  input  logic        io_inst_valid,
  output logic        io_inst_ready,
  input  logic        io_redirect_valid,
  input  logic [63:0] io_redirect_pc,
  output logic        io_out_valid,
  output logic [63:0] io_out_pc,
  output logic [31:0] io_out_inst,
  input  logic        io_out_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OUT  = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state;
  logic [63:0] fetch_pc;
  logic [63:0] next_pc;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        resp;

  // Control outputs decode directly from the state register, so they are glitch-free.
  assign io_pc_valid   = (state == S_REQ) || (state == S_DROP);
  assign io_inst_ready = (state == S_REQ) || (state == S_DROP);
  assign io_out_valid  = (state == S_OUT);
  assign io_pc         = fetch_pc;
  assign io_out_pc     = out_pc;
  assign io_out_inst   = out_inst;

  assign resp = io_inst_valid && io_inst_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      next_pc  <= RESET_PC;
      out_pc   <= RESET_PC;
      out_inst <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          fetch_pc <= RESET_PC;
          next_pc  <= RESET_PC;
          state    <= S_REQ;
        end
        S_REQ: begin
          if (io_redirect_valid && resp) begin
            // The response belongs to the stale path; restart at the target right away.
            fetch_pc <= io_redirect_pc;
            next_pc  <= io_redirect_pc;
          end else if (io_redirect_valid) begin
            // Request still in flight: io_pc must stay put until its response drains.
            next_pc <= io_redirect_pc;
            state   <= S_DROP;
          end else if (resp) begin
            out_pc   <= fetch_pc;
            out_inst <= io_inst;
            next_pc  <= fetch_pc + 64'd4;
            state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (io_redirect_valid) begin
            fetch_pc <= io_redirect_pc;
            next_pc  <= io_redirect_pc;
            state    <= S_REQ;
          end else if (io_out_ready) begin
            fetch_pc <= next_pc;
            state    <= S_REQ;
          end
        end
        S_DROP: begin
          if (resp) begin
            fetch_pc <= io_redirect_valid ? io_redirect_pc : next_pc;
            if (io_redirect_valid) next_pc <= io_redirect_pc;
            state <= S_REQ;
          end else if (io_redirect_valid) begin
            next_pc <= io_redirect_pc;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a scoreboard of expected decode transfers.
module tb_fetch_ctrl;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clock;
  logic        reset;
  logic [63:0] io_pc;
  logic        io_pc_valid;
  logic [31:0] io_inst;
  logic        io_inst_valid;
  logic        io_inst_ready;
  logic        io_redirect_valid;
  logic [63:0] io_redirect_pc;
  logic        io_out_valid;
  logic [63:0] io_out_pc;
  logic [31:0] io_out_inst;
  logic        io_out_ready;

  int checks = 0;
  int errors = 0;
  logic [95:0] exp_q[$];

  fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset),
    .io_pc(io_pc), .io_pc_valid(io_pc_valid),
    .io_inst(io_inst), .io_inst_valid(io_inst_valid), .io_inst_ready(io_inst_ready),
    .io_redirect_valid(io_redirect_valid), .io_redirect_pc(io_redirect_pc),
    .io_out_valid(io_out_valid), .io_out_pc(io_out_pc), .io_out_inst(io_out_inst),
    .io_out_ready(io_out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: any transfer to decode must match the oldest expected entry.
  always @(negedge clock) begin
    if (reset && io_out_valid && io_out_ready && !io_redirect_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h, required no transfer", io_out_pc, io_out_inst);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        if ({io_out_pc, io_out_inst} !== e) begin
          errors++;
          $display("FAIL sb_transfer: got pc=%h inst=%h, required pc=%h inst=%h",
                   io_out_pc, io_out_inst, e[95:32], e[31:0]);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({io_pc_valid, io_inst_ready, io_out_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b, required 000", {io_pc_valid, io_inst_ready, io_out_valid});
    end
    checks++;
    if (io_pc !== RPC || io_out_pc !== RPC || io_out_inst !== 32'd0) begin
      errors++; $display("FAIL reset_regs: got pc=%h out_pc=%h out_inst=%h, required %h %h 0", io_pc, io_out_pc, io_out_inst, RPC, RPC);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (io_pc_valid !== 1'b1 || io_pc !== RPC || io_out_valid !== 1'b0) begin
      errors++; $display("FAIL first_req: got valid=%b pc=%h out_valid=%b, required 1 %h 0", io_pc_valid, io_pc, io_out_valid, RPC);
    end
  endtask

  task automatic test_basic();
    io_out_ready = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (io_pc_valid !== 1'b1 || io_pc !== RPC || io_inst_ready !== 1'b1) begin
        errors++; $display("FAIL basic_hold: got valid=%b pc=%h ready=%b, required 1 %h 1", io_pc_valid, io_pc, io_inst_ready, RPC);
      end
    end
    io_inst = 32'h0000_0013; io_inst_valid = 1'b1;
    exp_q.push_back({RPC, 32'h0000_0013});
    tick();
    io_inst_valid = 1'b0;
    checks++;
    if (io_out_valid !== 1'b1 || io_pc_valid !== 1'b0) begin
      errors++; $display("FAIL basic_out: got out_valid=%b pc_valid=%b, required 1 0", io_out_valid, io_pc_valid);
    end
    tick();
    checks++;
    if (io_pc_valid !== 1'b1 || io_pc !== 64'h8000_0004) begin
      errors++; $display("FAIL basic_next: got valid=%b pc=%h, required 1 80000004", io_pc_valid, io_pc);
    end
  endtask

  task automatic test_backpressure();
    io_out_ready = 1'b0;
    io_inst = 32'h0000_AAAA; io_inst_valid = 1'b1;
    exp_q.push_back({64'h8000_0004, 32'h0000_AAAA});
    tick();
    for (int i = 0; i < 5; i++) begin
      io_inst = 32'hDEAD_0000 + i; io_inst_valid = 1'b1;
      checks++;
      if (io_out_valid !== 1'b1 || io_out_pc !== 64'h8000_0004 || io_out_inst !== 32'h0000_AAAA ||
          io_pc_valid !== 1'b0 || io_inst_ready !== 1'b0) begin
        errors++; $display("FAIL bp_stall: got ov=%b pc=%h inst=%h pv=%b rdy=%b, required 1 80000004 0000aaaa 0 0",
                           io_out_valid, io_out_pc, io_out_inst, io_pc_valid, io_inst_ready);
      end
      tick();
    end
    io_inst_valid = 1'b0;
    io_out_ready = 1'b1;
    tick();
    checks++;
    if (io_pc_valid !== 1'b1 || io_pc !== 64'h8000_0008) begin
      errors++; $display("FAIL bp_next: got valid=%b pc=%h, required 1 80000008", io_pc_valid, io_pc);
    end
  endtask

  task automatic test_redirect_wait();
    io_redirect_valid = 1'b1; io_redirect_pc = 64'h8000_1000;
    tick();
    io_redirect_valid = 1'b0;
    checks++;
    if (io_pc_valid !== 1'b1 || io_pc !== 64'h8000_0008 || io_out_valid !== 1'b0) begin
      errors++; $display("FAIL rw_drop: got valid=%b pc=%h ov=%b, required 1 80000008 0", io_pc_valid, io_pc, io_out_valid);
    end
    tick();
    io_inst = 32'hBAD0_0001; io_inst_valid = 1'b1;
    tick();
    io_inst_valid = 1'b0;
    checks++;
    if (io_pc_valid !== 1'b1 || io_pc !== 64'h8000_1000 || io_out_valid !== 1'b0) begin
      errors++; $display("FAIL rw_next: got valid=%b pc=%h ov=%b, required 1 80001000 0", io_pc_valid, io_pc, io_out_valid);
    end
  endtask

  task automatic test_redirect_same_cycle();
    io_redirect_valid = 1'b1; io_redirect_pc = 64'h8000_0004;
    io_inst = 32'hBAD0_0002; io_inst_valid = 1'b1;
    tick();
    checks++;
    if (io_pc !== 64'h8000_0004 || io_out_valid !== 1'b0 || io_pc_valid !== 1'b1) begin
      errors++; $display("FAIL sc_first: got pc=%h ov=%b pv=%b, required 80000004 0 1", io_pc, io_out_valid, io_pc_valid);
    end
    io_redirect_pc = 64'h8000_2000; io_inst = 32'hBAD0_0003;
    tick();
    io_redirect_valid = 1'b0; io_inst_valid = 1'b0;
    tick();
    checks++;
    if (io_pc !== 64'h8000_2000 || io_out_valid !== 1'b0 || io_pc_valid !== 1'b1) begin
      errors++; $display("FAIL sc_second: got pc=%h ov=%b pv=%b, required 80002000 0 1", io_pc, io_out_valid, io_pc_valid);
    end
    io_inst = 32'h0000_BEEF; io_inst_valid = 1'b1;
    exp_q.push_back({64'h8000_2000, 32'h0000_BEEF});
    tick();
    io_inst_valid = 1'b0;
    tick();
    checks++;
    if (io_pc !== 64'h8000_2004 || io_pc_valid !== 1'b1) begin
      errors++; $display("FAIL sc_next: got pc=%h pv=%b, required 80002004 1", io_pc, io_pc_valid);
    end
  endtask

  task automatic test_drop_multi();
    io_redirect_valid = 1'b1; io_redirect_pc = 64'h100;
    tick();
    io_redirect_pc = 64'h200;
    tick();
    io_redirect_valid = 1'b0;
    checks++;
    if (io_pc !== 64'h8000_2004 || io_pc_valid !== 1'b1 || io_inst_ready !== 1'b1 || io_out_valid !== 1'b0) begin
      errors++; $display("FAIL dm_hold: got pc=%h pv=%b rdy=%b ov=%b, required 80002004 1 1 0", io_pc, io_pc_valid, io_inst_ready, io_out_valid);
    end
    io_inst = 32'hBAD0_0004; io_inst_valid = 1'b1;
    tick();
    io_inst_valid = 1'b0;
    checks++;
    if (io_pc !== 64'h200 || io_pc_valid !== 1'b1 || io_out_valid !== 1'b0) begin
      errors++; $display("FAIL dm_latest: got pc=%h pv=%b ov=%b, required 200 1 0", io_pc, io_pc_valid, io_out_valid);
    end
    io_redirect_valid = 1'b1; io_redirect_pc = 64'h300;
    tick();
    io_redirect_pc = 64'h400; io_inst = 32'hBAD0_0005; io_inst_valid = 1'b1;
    tick();
    io_redirect_valid = 1'b0; io_inst_valid = 1'b0;
    checks++;
    if (io_pc !== 64'h400 || io_pc_valid !== 1'b1 || io_out_valid !== 1'b0) begin
      errors++; $display("FAIL dm_coincide: got pc=%h pv=%b ov=%b, required 400 1 0", io_pc, io_pc_valid, io_out_valid);
    end
  endtask

  task automatic test_out_redirect();
    io_out_ready = 1'b0;
    io_inst = 32'h0000_5555; io_inst_valid = 1'b1;
    tick();
    io_inst_valid = 1'b0;
    checks++;
    if (io_out_valid !== 1'b1 || io_out_pc !== 64'h400 || io_out_inst !== 32'h0000_5555) begin
      errors++; $display("FAIL or_buf: got ov=%b pc=%h inst=%h, required 1 400 00005555", io_out_valid, io_out_pc, io_out_inst);
    end
    io_redirect_valid = 1'b1; io_redirect_pc = 64'h500;
    tick();
    io_redirect_valid = 1'b0;
    checks++;
    if (io_out_valid !== 1'b0 || io_pc_valid !== 1'b1 || io_pc !== 64'h500) begin
      errors++; $display("FAIL or_drop: got ov=%b pv=%b pc=%h, required 0 1 500", io_out_valid, io_pc_valid, io_pc);
    end
  endtask

  task automatic test_wrap();
    io_redirect_valid = 1'b1; io_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    io_inst = 32'hBAD0_0006; io_inst_valid = 1'b1;
    tick();
    io_redirect_valid = 1'b0; io_inst_valid = 1'b0;
    checks++;
    if (io_pc !== 64'hFFFF_FFFF_FFFF_FFFC || io_pc_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_req: got pc=%h pv=%b, required fffffffffffffffc 1", io_pc, io_pc_valid);
    end
    io_out_ready = 1'b1;
    io_inst = 32'h0000_0077; io_inst_valid = 1'b1;
    exp_q.push_back({64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0077});
    tick();
    io_inst_valid = 1'b0;
    tick();
    checks++;
    if (io_pc !== 64'd0 || io_pc_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_next: got pc=%h pv=%b, required 0 1", io_pc, io_pc_valid);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({io_pc_valid, io_inst_ready, io_out_valid} !== 3'b000 || io_pc !== RPC) begin
      errors++; $display("FAIL rm_async: got ctrl=%b pc=%h, required 000 %h", {io_pc_valid, io_inst_ready, io_out_valid}, io_pc, RPC);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (io_pc_valid !== 1'b1 || io_pc !== RPC || io_out_valid !== 1'b0) begin
      errors++; $display("FAIL rm_restart: got pv=%b pc=%h ov=%b, required 1 %h 0", io_pc_valid, io_pc, io_out_valid, RPC);
    end
  endtask

  initial begin
    reset = 1'b0;
    io_inst = 32'd0; io_inst_valid = 1'b0;
    io_redirect_valid = 1'b0; io_redirect_pc = 64'd0;
    io_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_drop_multi();
    test_out_redirect();
    test_wrap();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
